shift_seq_unit: RTL and testbench
=================================

SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width, power of two, at least 8.
REQ-002 SHALL have parameter AMT_SRCS, default 3: number of shift-amount sources, 2..8.
REQ-003 SHALL derive AMT_W = clog2(WIDTH) and SEL_W = clog2(AMT_SRCS) as localparams.
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: start  input  1  request a shift; sampled only in IDLE.
REQ-007 SHALL have port: op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-008 SHALL have port: amt_sel  input  SEL_W  index of the amount source.
REQ-009 SHALL have port: amt_in  input  AMT_SRCS*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port: data_in  input  WIDTH  operand.
REQ-011 SHALL have port: data_out  output  WIDTH  registered result.
REQ-012 SHALL have port: busy  output  1  high while in SHIFT or DONE.
REQ-013 SHALL have port: done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 SHALL do the following in the same edge:
  - latch data_in into the working register;
  - latch op;
  - latch amount = amt_in[amt_sel][AMT_W-1:0].
  Upper amount bits SHALL be ignored.
REQ-016 From IDLE: amount=0 SHALL go to DONE; otherwise the FSM SHALL go to SHIFT.
REQ-017 amt_sel >= AMT_SRCS SHALL select amount 0.
REQ-018 SHIFT SHALL shift the working register one bit per cycle and decrement the counter.
REQ-019 SHIFT SHALL go to DONE on the cycle the counter reaches 0.
REQ-020 Per-bit operation:
  - SLL and SRL fill with 0;
  - SRA replicates the MSB;
  - ROR moves bit 0 into the MSB.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge amount+1.
  - amount=0 gives done after edge 1.
REQ-023 data_out SHALL hold the final result from DONE until the next accepted start.
REQ-024 data_out SHALL show intermediate values during SHIFT.
REQ-025 start while busy=1 SHALL be ignored and not queued.
REQ-026 start in the DONE cycle SHALL be ignored; it is accepted only from IDLE.
REQ-027 Changes on data_in, op, amt_sel or amt_in after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-028 reset=1 at a clock edge SHALL force the following, overriding start:
  - state IDLE;
  - data_out=0, counter=0;
  - busy=0, done=0.
REQ-029 reset asserted mid-SHIFT SHALL abort the operation with no done pulse.
REQ-030 The first start SHALL be accepted on the first edge after reset deasserts.

Configuration
REQ-031 Macro SHIFT_BARREL_EN, when defined, SHALL compile in a single-cycle barrel shifter.
  - IDLE+start SHALL go straight to DONE with the full shifted result.
  - done SHALL follow after edge 1 for any amount.
  - The SHIFT state and counter SHALL be absent.
REQ-032 Without SHIFT_BARREL_EN, the iterative behaviour of REQ-018..REQ-022 SHALL apply.
REQ-033 Final results SHALL be identical in both builds.

Structure
REQ-034 Package shift_pkg SHALL hold the op encodings (SH_SLL, SH_SRL, SH_SRA, SH_ROR) and the state type (IDLE, SHIFT, DONE).
REQ-035 Amount selection SHALL be the sub-module shift_amt_sel.
  - Parameters: WIDTH, AMT_SRCS.
  - Purely combinational.
  - Output is AMT_W bits; out-of-range select gives 0.

Verification
REQ-036 WIDTH=32: data_in=0x80000001, op=SRA, amount source 1 = 4.
  - done after edge 5;
  - data_out=0xF8000000.
REQ-037 data_in=0x0000000F, op=SLL, amount source 0 = 0x25 (masked to 5).
  - done after edge 6;
  - data_out=0x000001E0.
REQ-038 data_in=0x12345678, op=ROR, amount=0.
  - done after edge 1;
  - data_out=0x12345678.
REQ-039 amt_sel=3 with AMT_SRCS=3: amount 0; data_out=data_in after edge 1.
REQ-040 Start an SRL by 31 and pulse reset at edge 10.
  - busy=0, data_out=0, no done pulse.
  - A new start at edge 11 is accepted.
REQ-041 Start asserted continuously through SHIFT and DONE.
  - Exactly one operation completes; the next is accepted only from IDLE.
  - Repeat in a SHIFT_BARREL_EN build: each shift completes in 2 cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: operation encodings and FSM state type shared by the shift unit.
package shift_pkg;

    // Shift operation selected by the op port
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_t;

    // Control states; SHIFT is only reached in the iterative build
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_amt_sel.sv
// shift_amt_sel: picks one of AMT_SRCS packed amount sources and keeps only the
// low AMT_W bits. Select values past the last source yield an amount of zero.
// Purely combinational.
module shift_amt_sel #(
    parameter int  WIDTH    = 32,
    parameter int  AMT_SRCS = 3,
    localparam int AMT_W    = $clog2(WIDTH),
    localparam int SEL_W    = $clog2(AMT_SRCS)
) (
    input  logic [SEL_W-1:0]          amt_sel,
    input  logic [AMT_SRCS*WIDTH-1:0] amt_in,
    output logic [AMT_W-1:0]          amt
);

    localparam int NUM_SLOTS = 2 ** SEL_W;

    // One slot per encodable select value; slots without a source read as zero
    logic [AMT_W-1:0] slot_amt [NUM_SLOTS];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        if (gi < AMT_SRCS) begin : g_src
            assign slot_amt[gi] = amt_in[gi*WIDTH +: AMT_W];
        end else begin : g_none
            assign slot_amt[gi] = '0;
        end
    end

    assign amt = slot_amt[amt_sel];

    // Upper bits of every source are intentionally discarded
    logic unused_upper_bits;
    assign unused_upper_bits = ^amt_in;

endmodule

// File: rtl/shift_seq_unit.sv
// shift_seq_unit: shift/rotate unit with a selectable amount source.
// Default build shifts the working register one bit per cycle. Defining
// SHIFT_BARREL_EN replaces the iterative path with a single-cycle barrel
// shifter (no SHIFT state, no counter); final results are the same.
// done is registered, so it pulses in the cycle after the DONE state.
module shift_seq_unit
    import shift_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  AMT_SRCS = 3,
    localparam int AMT_W    = $clog2(WIDTH),
    localparam int SEL_W    = $clog2(AMT_SRCS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [SEL_W-1:0]          amt_sel,
    input  logic [AMT_SRCS*WIDTH-1:0] amt_in,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      busy,
    output logic                      done
);

    shift_state_t     state_reg, state_next;
    logic [WIDTH-1:0] data_reg,  data_next;
    logic             done_reg,  done_next;
    logic [AMT_W-1:0] amt_val;

    shift_amt_sel #(
        .WIDTH    (WIDTH),
        .AMT_SRCS (AMT_SRCS)
    ) u_amt_sel (
        .amt_sel (amt_sel),
        .amt_in  (amt_in),
        .amt     (amt_val)
    );

`ifdef SHIFT_BARREL_EN
    // Shift by a constant distance k; rotate uses a doubled copy of the word
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input shift_op_t o,
                                                  input int k);
        logic [2*WIDTH-1:0] dd;
        dd = {d, d} >> k;
        case (o)
            SH_SLL:  return d << k;
            SH_SRL:  return d >> k;
            SH_SRA:  return $unsigned($signed(d) >>> k);
            default: return dd[WIDTH-1:0];
        endcase
    endfunction

    // Logarithmic stages: stage gi applies a 2**gi shift when amount bit gi is set
    logic [WIDTH-1:0] stage [AMT_W+1];
    logic [WIDTH-1:0] barrel_result;

    assign stage[0] = data_in;
    for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
        assign stage[gi+1] = amt_val[gi] ? shift_by(stage[gi], shift_op_t'(op), 2 ** gi)
                                         : stage[gi];
    end
    assign barrel_result = stage[AMT_W];
`else
    shift_op_t        op_reg,  op_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;

    // One-bit step of the latched operation
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] d,
                                                   input shift_op_t o);
        case (o)
            SH_SLL:  return {d[WIDTH-2:0], 1'b0};
            SH_SRL:  return {1'b0, d[WIDTH-1:1]};
            SH_SRA:  return {d[WIDTH-1], d[WIDTH-1:1]};
            default: return {d[0], d[WIDTH-1:1]};
        endcase
    endfunction
`endif

    // Next-state and datapath: accept only from IDLE, step in SHIFT, pulse from DONE
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
`ifndef SHIFT_BARREL_EN
        op_next    = op_reg;
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
`ifdef SHIFT_BARREL_EN
                    data_next  = barrel_result;
                    state_next = DONE;
`else
                    data_next  = data_in;
                    op_next    = shift_op_t'(op);
                    cnt_next   = amt_val;
                    state_next = (amt_val == '0) ? DONE : SHIFT;
`endif
                end
            end
`ifndef SHIFT_BARREL_EN
            SHIFT: begin
                data_next = shift_one(data_reg, op_reg);
                cnt_next  = cnt_reg - AMT_W'(1);
                if (cnt_reg == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset overrides any pending start
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            done_reg  <= 1'b0;
`ifndef SHIFT_BARREL_EN
            op_reg    <= SH_SLL;
            cnt_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            done_reg  <= done_next;
`ifndef SHIFT_BARREL_EN
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
`endif
        end
    end

    assign data_out = data_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb_shift_seq_unit: directed bench with a timeline model of the shift unit.
// Honours SHIFT_BARREL_EN to expect the single-cycle build.
module tb_shift_seq_unit;

    localparam int W    = 32;
    localparam int SRCS = 3;
`ifdef SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [1:0]      amt_sel = 2'b00;
    logic [SRCS*W-1:0] amt_in = '0;
    logic [W-1:0]    data_in = '0;
    logic [W-1:0]    data_out;
    logic            busy;
    logic            done;

    shift_seq_unit #(.WIDTH(W), .AMT_SRCS(SRCS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .amt_sel  (amt_sel),
        .amt_in   (amt_in),
        .data_in  (data_in),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Reference result straight from the operation definitions
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [1:0] o, input int a);
        case (o)
            OP_SLL:  return d << a;
            OP_SRL:  return d >> a;
            OP_SRA:  return $unsigned($signed(d) >>> a);
            default: return (a == 0) ? d : ((d >> a) | (d << (W - a)));
        endcase
    endfunction

    // Model: an accepted op at edge t0 with amount a completes at edge t0+lat
    bit           m_acc = 1'b0;
    int           m_t0 = 0;
    int           m_done_edge = 0;
    int           m_amt = 0;
    logic [W-1:0] m_d = '0;
    logic [1:0]   m_op = 2'b00;
    logic [W-1:0] m_final = '0;

    always @(posedge clk) begin
        int j, lat;
        logic [W-1:0] ed;
        logic eb, edn;
        edge_n++;
        if (reset) begin
            m_acc = 1'b0;
        end else if (start && (!m_acc || edge_n > m_done_edge)) begin
            m_acc  = 1'b1;
            m_t0   = edge_n;
            m_d    = data_in;
            m_op   = op;
            m_amt  = (amt_sel < SRCS) ? int'(amt_in[amt_sel*W +: 5]) : 0;
            m_final = ref_shift(m_d, m_op, m_amt);
            m_done_edge = edge_n + (BARREL ? 1 : m_amt + 1);
        end
        #1;
        if (!m_acc) begin
            ed = '0; eb = 1'b0; edn = 1'b0;
        end else begin
            j   = edge_n - m_t0;
            lat = m_done_edge - m_t0;
            if (j < lat) begin
                eb = 1'b1; edn = 1'b0;
                ed = BARREL ? m_final : ref_shift(m_d, m_op, j);
            end else if (j == lat) begin
                eb = 1'b0; edn = 1'b1; ed = m_final;
            end else begin
                eb = 1'b0; edn = 1'b0; ed = m_final;
            end
        end
        check("cyc_data", data_out, ed);
        check("cyc_busy", W'(busy), W'(eb));
        check("cyc_done", W'(done), W'(edn));
        if (done) done_cnt++;
    end

    // Wait for done after start edge e0; check latency and result literals
    task automatic wait_done(input string name, input int e0, input int exp_lat, input logic [W-1:0] exp_d);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 80 cycles", name);
        end else begin
            check({name, "_lat"}, W'(edge_n - e0), W'(exp_lat));
            check({name, "_data"}, data_out, exp_d);
            $display("[TB] %s: lat %0d data %h", name, edge_n - e0, data_out);
        end
    endtask

    // One-cycle start pulse, then scramble inputs to show they are not re-read
    task automatic run_op(input string name, input logic [W-1:0] d, input logic [1:0] o,
                          input logic [1:0] sel, input logic [SRCS*W-1:0] srcs,
                          input logic [W-1:0] exp_d, input int exp_lat);
        int e0;
        @(negedge clk);
        data_in = d; op = o; amt_sel = sel; amt_in = srcs; start = 1'b1;
        e0 = edge_n + 1;
        @(negedge clk);
        start   = 1'b0;
        data_in = $urandom;
        op      = 2'($urandom_range(0, 3));
        amt_sel = 2'($urandom_range(0, 3));
        amt_in  = {$urandom, $urandom, $urandom};
        wait_done(name, e0, exp_lat, exp_d);
    endtask

    initial begin
        int s, d0;
        repeat (3) @(negedge clk);
        check("rst_data", data_out, 32'h0);
        check("rst_busy", W'(busy), 32'h0);
        check("rst_done", W'(done), 32'h0);
        reset = 1'b0;

        run_op("sra4",   32'h80000001, OP_SRA, 2'd1, {32'd0, 32'd4, 32'd0},         32'hF8000000, BARREL ? 1 : 5);
        run_op("sll25",  32'h0000000F, OP_SLL, 2'd0, {32'd0, 32'd0, 32'h25},        32'h000001E0, BARREL ? 1 : 6);
        run_op("ror0",   32'h12345678, OP_ROR, 2'd2, {32'd0, 32'd9, 32'd9},         32'h12345678, 1);
        run_op("sel3",   32'h000000A5, OP_SLL, 2'd3, {32'd7, 32'd7, 32'd7},         32'h000000A5, 1);
        run_op("ror8",   32'h12345678, OP_ROR, 2'd0, {32'd0, 32'd0, 32'd8},         32'h78123456, BARREL ? 1 : 9);
        run_op("srl31",  32'h80000000, OP_SRL, 2'd2, {32'd31, 32'd0, 32'd0},        32'h00000001, BARREL ? 1 : 32);
        run_op("sra31",  32'h80000000, OP_SRA, 2'd1, {32'd0, 32'd31, 32'd0},        32'hFFFFFFFF, BARREL ? 1 : 32);
        run_op("sra3p",  32'h40000000, OP_SRA, 2'd0, {32'd0, 32'd0, 32'd3},         32'h08000000, BARREL ? 1 : 4);
        run_op("ror1",   32'h00000001, OP_ROR, 2'd1, {32'd0, 32'd1, 32'd0},         32'h80000000, BARREL ? 1 : 2);
        run_op("sll3f",  32'hFFFFFFFF, OP_SLL, 2'd0, {32'd0, 32'd0, 32'hFFFFFF3F},  32'h80000000, BARREL ? 1 : 32);

        // Reset pulse while an SRL by 31 is in flight
        @(negedge clk);
        data_in = 32'h80000000; op = OP_SRL; amt_sel = 2'd2; amt_in = {32'd31, 32'd0, 32'd0};
        start = 1'b1;
        s = edge_n + 1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        while (edge_n < s + 9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", W'(busy), 32'h0);
        check("abort_data", data_out, 32'h0);
        check("abort_done_cnt", W'(done_cnt - d0), BARREL ? 32'd1 : 32'd0);
        // Start on the first edge after reset release
        data_in = 32'h00000003; op = OP_SLL; amt_sel = 2'd0; amt_in = {32'd0, 32'd0, 32'd2};
        start = 1'b1;
        s = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_busy", W'(busy), 32'h1);
        wait_done("post_rst", s, BARREL ? 1 : 3, 32'h0000000C);

        // start held high for 10 edges: one op per full IDLE-to-IDLE period
        @(negedge clk);
        data_in = 32'h00000001; op = OP_SLL; amt_sel = 2'd0; amt_in = {32'd0, 32'd0, 32'd3};
        d0 = done_cnt;
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("held_start_ops", W'(done_cnt - d0), BARREL ? 32'd5 : 32'd2);
        $display("[TB] held start: %0d completions", done_cnt - d0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
